// File: rtl/weight_tile_loader.sv
// Weight tile loader: streams weight rows into the systolic array's shadow
// registers and flips per-PE buffer selects in a diagonal wavefront.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   stall_i               global pipeline stall shared with the array
//   w_row_valid_i/ready_o row stream handshake, w_row_i element c -> column c
//   swap_req_i            pulse: switch the array to the buffered tile
//   load_weights_o        row shift enables to the array
//   mem_weight_o          weight row to the array
//   compute_weight_sel_o  per-PE select, PE(r,c) is bit [r][MUL_SIZE-1-c]
//   weights_buffered_o    shadow registers hold a complete tile
//   weights_rdy_o         active registers hold a valid tile
//   swap_done_o           pulse on the last wavefront step
module weight_tile_loader #(
    parameter int MUL_SIZE = 4,
    parameter int W_WIDTH  = 7
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   stall_i,
    input  logic                                   w_row_valid_i,
    output logic                                   w_row_ready_o,
    input  logic [MUL_SIZE-1:0][W_WIDTH:0]         w_row_i,
    input  logic                                   swap_req_i,
    output logic [MUL_SIZE-1:0]                    load_weights_o,
    output logic [MUL_SIZE-1:0][W_WIDTH:0]         mem_weight_o,
    output logic [MUL_SIZE-1:0][MUL_SIZE-1:0]      compute_weight_sel_o,
    output logic                                   weights_buffered_o,
    output logic                                   weights_rdy_o,
    output logic                                   swap_done_o
);

    localparam int CW = $clog2(MUL_SIZE + 1);
    localparam int TW = $clog2(2 * MUL_SIZE);
    localparam logic [CW-1:0] ROW_LAST = CW'(MUL_SIZE - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(2 * MUL_SIZE - 2);

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        FULL,
        SWAP
    } state_t;

    state_t                            state_q, state_d;
    logic [CW-1:0]                     row_cnt_q, row_cnt_d;
    logic [TW-1:0]                     t_q, t_d;
    logic                              pending_q, pending_d;
    logic                              rdy_q, rdy_d;
    logic [MUL_SIZE-1:0][MUL_SIZE-1:0] sel_q, sel_d;
    logic                              loading;
    logic                              acc;

    assign loading = (state_q == EMPTY) || (state_q == LOAD);

    // Outputs are forced low while reset is applied so the array never sees
    // a stray shift from a tile that reset is about to discard.
    assign w_row_ready_o        = loading && !stall_i && !rst_i;
    assign acc                  = w_row_valid_i && w_row_ready_o;
    assign load_weights_o       = {MUL_SIZE{acc}};
    assign mem_weight_o         = w_row_i;
    assign compute_weight_sel_o = sel_q;
    assign weights_buffered_o   = (state_q == FULL);
    assign weights_rdy_o        = rdy_q;
    assign swap_done_o          = (state_q == SWAP) && (t_q == T_LAST)
                                  && !stall_i && !rst_i;

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        t_d       = t_q;
        pending_d = pending_q;
        rdy_d     = rdy_q;
        sel_d     = sel_q;

        if (!stall_i) begin
            unique case (state_q)
                EMPTY, LOAD: begin
                    if (acc) begin
                        if (row_cnt_q == ROW_LAST) begin
                            state_d   = FULL;
                            row_cnt_d = '0;
                        end else begin
                            state_d   = LOAD;
                            row_cnt_d = row_cnt_q + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (swap_req_i || pending_q) begin
                        state_d   = SWAP;
                        t_d       = '0;
                        pending_d = 1'b0;
                    end
                end
                SWAP: begin
                    // Anti-diagonal r+c==t swaps together, matching the skew
                    // of the activation front entering the array.
                    for (int r = 0; r < MUL_SIZE; r++) begin
                        for (int c = 0; c < MUL_SIZE; c++) begin
                            if (r + c == int'(t_q)) begin
                                sel_d[r][MUL_SIZE-1-c] = !sel_q[r][MUL_SIZE-1-c];
                            end
                        end
                    end
                    if (t_q == T_LAST) begin
                        state_d = EMPTY;
                        t_d     = '0;
                        rdy_d   = 1'b1;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end

        // Early requests are remembered; a stalled FULL also remembers one.
        // Requests during SWAP are dropped.
        if (swap_req_i && (state_q != SWAP)
            && (stall_i || (state_q != FULL))) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= EMPTY;
            row_cnt_q <= '0;
            t_q       <= '0;
            pending_q <= 1'b0;
            rdy_q     <= 1'b0;
            sel_q     <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            t_q       <= t_d;
            pending_q <= pending_d;
            rdy_q     <= rdy_d;
            sel_q     <= sel_d;
        end
    end

endmodule
